// File: rtl/sync_fifo_ext_if.sv
// Request/response bundle for sync_fifo_ext. The owner of the FIFO drives it through
// the master modport; the FIFO itself attaches through the slave modport.
interface sync_fifo_ext_if #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 64
);
  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);

  logic                  clr_i;
  logic                  push_i;
  logic [FIFO_WIDTH-1:0] wr_data_i;
  logic                  pop_i;
  logic [FIFO_WIDTH-1:0] rd_data_o;
  logic [ADDR_WIDTH:0]   a_full_thr_i;
  logic [ADDR_WIDTH:0]   a_empty_thr_i;
  logic [ADDR_WIDTH:0]   level_o;
  logic                  full_o;
  logic                  a_full_o;
  logic                  empty_o;
  logic                  a_empty_o;
  logic                  overflow_o;
  logic                  underflow_o;

  modport master (
    output clr_i, push_i, wr_data_i, pop_i, a_full_thr_i, a_empty_thr_i,
    input  rd_data_o, level_o, full_o, a_full_o, empty_o, a_empty_o, overflow_o, underflow_o
  );

  modport slave (
    input  clr_i, push_i, wr_data_i, pop_i, a_full_thr_i, a_empty_thr_i,
    output rd_data_o, level_o, full_o, a_full_o, empty_o, a_empty_o, overflow_o, underflow_o
  );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO with standard or first-word-fall-through read, occupancy count,
// run-time almost-full/almost-empty thresholds, synchronous flush and sticky error flags.
module sync_fifo_ext #(
  parameter int unsigned FIFO_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 64,
  parameter string       READ_MODE  = "std"
) (
  input logic            clk_i,
  input logic            rstn_i,
  sync_fifo_ext_if.slave bus
);
  localparam int unsigned ADDR_WIDTH = $clog2(FIFO_DEPTH);
  localparam bit          Fwft       = (READ_MODE == "fwft");

  localparam logic [ADDR_WIDTH:0]   LvlFull = (ADDR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [ADDR_WIDTH:0]   LvlOne  = (ADDR_WIDTH + 1)'(1);
  localparam logic [ADDR_WIDTH-1:0] PtrOne  = ADDR_WIDTH'(1);

  logic [FIFO_WIDTH-1:0] mem_q [FIFO_DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [FIFO_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  overflow_q, overflow_d;
  logic                  underflow_q, underflow_d;

  logic full, empty, wr_en, rd_en, mem_we, mem_low;

  // Status decodes and accepted-request qualification.
  always_comb begin
    full    = (level_q == LvlFull);
    empty   = (level_q == '0);
    wr_en   = bus.push_i & ~full;
    rd_en   = bus.pop_i & ~empty;
    // In fwft the head lives in rd_data_q, so memory is empty whenever level <= 1.
    mem_low = (level_q <= LvlOne);
  end

  // Next-state for pointers, level, output register and error flags.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q | (bus.push_i & full);
    underflow_d = underflow_q | (bus.pop_i & empty);
    mem_we      = 1'b0;
    if (bus.clr_i) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      level_d     = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (wr_en && !rd_en) begin
        level_d = level_q + LvlOne;
      end else if (rd_en && !wr_en) begin
        level_d = level_q - LvlOne;
      end
      if (Fwft) begin
        if (rd_en) begin
          if (!mem_low) begin
            rd_data_d = mem_q[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PtrOne;
            mem_we    = wr_en;
          end else if (wr_en) begin
            // Head consumed with memory empty: incoming word becomes the new head.
            rd_data_d = bus.wr_data_i;
          end
        end else if (wr_en) begin
          if (empty) begin
            rd_data_d = bus.wr_data_i;
          end else begin
            mem_we = 1'b1;
          end
        end
      end else begin
        mem_we = wr_en;
        if (rd_en) begin
          rd_data_d = mem_q[rd_ptr_q];
          rd_ptr_d  = rd_ptr_q + PtrOne;
        end
      end
      if (mem_we) begin
        wr_ptr_d = wr_ptr_q + PtrOne;
      end
    end
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      mem_q[wr_ptr_q] <= bus.wr_data_i;
    end
  end

  assign bus.rd_data_o   = rd_data_q;
  assign bus.level_o     = level_q;
  assign bus.full_o      = full;
  assign bus.empty_o     = empty;
  assign bus.a_full_o    = (level_q >= bus.a_full_thr_i);
  assign bus.a_empty_o   = (level_q <= bus.a_empty_thr_i);
  assign bus.overflow_o  = overflow_q;
  assign bus.underflow_o = underflow_q;

endmodule
